// File: rtl/dot_accel_pkg.sv
// dot_accel_pkg: register map, FSM states and fixed-point defaults for dot_accel
package dot_accel_pkg;
  localparam int FRAC_BITS_DEF = 16;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_WBASE  = 3'd1;
  localparam logic [2:0] REG_ABASE  = 3'd2;
  localparam logic [2:0] REG_BIAS   = 3'd3;
  localparam logic [2:0] REG_OUT    = 3'd4;
  localparam logic [2:0] REG_LEN    = 3'd5;
  localparam logic [2:0] REG_RELU   = 3'd6;
  localparam logic [2:0] REG_RESULT = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_RD_W, S_WT_W, S_RD_A, S_WT_A, S_MAC, S_WR} state_t;
endpackage

// File: rtl/dot_mac.sv
// dot_mac: registered signed fixed-point multiply-accumulate with bias load
module dot_mac #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] bias,
  input  logic [31:0] w,
  input  logic [31:0] a,
  output logic [31:0] acc
);
  logic [31:0] acc_q, acc_d;
  logic signed [63:0] prod;
  always_comb begin
    prod = $signed(w) * $signed(a);
    acc_d = load ? bias : en ? acc_q + 32'(prod >>> FRAC_BITS) : acc_q;
  end
  always_ff @(posedge clk) acc_q <= reset ? '0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/dot_accel.sv
// dot_accel: Avalon-MM Q16.16 dot-product engine; optional output ReLU via DOT_ACCEL_RELU_EN
module dot_accel
  import dot_accel_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  output logic              slave_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  input  logic              master_waitrequest
);
  state_t      state_q, state_d;
  logic [31:0] index_q, index_d, w_q, w_d, a_q, a_d;
  logic [31:0] wbase_q, wbase_d, abase_q, abase_d, bias_q, bias_d;
  logic [31:0] oaddr_q, oaddr_d, len_q, len_d, result_q, result_d;
  logic [31:0] rdata_q, rdata_d, rd_val, acc, final_val;
  logic        busy, wr_acc, rd_acc, start;
  assign busy   = state_q != S_IDLE;
  assign wr_acc = slave_write && !busy;
  assign rd_acc = slave_read && !busy;
  assign start  = wr_acc && slave_address == REG_CTRL;
`ifdef DOT_ACCEL_RELU_EN
  logic relu_q, relu_d;
  assign relu_d    = (wr_acc && slave_address == REG_RELU) ? slave_writedata[0] : relu_q;
  assign final_val = (relu_q && acc[31]) ? '0 : acc;
  always_ff @(posedge clk) relu_q <= reset ? 1'b0 : relu_d;
`else
  assign final_val = acc;
`endif
  dot_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
    .clk(clk), .reset(reset), .load(start), .en(state_q == S_MAC),
    .bias(bias_q), .w(w_q), .a(a_q), .acc(acc)
  );
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    w_d      = w_q;
    a_d      = a_q;
    wbase_d  = (wr_acc && slave_address == REG_WBASE) ? slave_writedata : wbase_q;
    abase_d  = (wr_acc && slave_address == REG_ABASE) ? slave_writedata : abase_q;
    bias_d   = (wr_acc && slave_address == REG_BIAS) ? slave_writedata : bias_q;
    oaddr_d  = (wr_acc && slave_address == REG_OUT) ? slave_writedata : oaddr_q;
    len_d    = (wr_acc && slave_address == REG_LEN) ? slave_writedata : len_q;
    result_d = (state_q == S_WR && !master_waitrequest) ? final_val : result_q;
    rd_val   = '0;
    case (slave_address)
      REG_CTRL:   rd_val = {31'b0, busy};
      REG_WBASE:  rd_val = wbase_q;
      REG_ABASE:  rd_val = abase_q;
      REG_BIAS:   rd_val = bias_q;
      REG_OUT:    rd_val = oaddr_q;
      REG_LEN:    rd_val = len_q;
`ifdef DOT_ACCEL_RELU_EN
      REG_RELU:   rd_val = {31'b0, relu_q};
`endif
      REG_RESULT: rd_val = result_q;
      default:    rd_val = '0;
    endcase
    rdata_d = rd_acc ? rd_val : rdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        index_d = '0;
        state_d = (len_q == '0) ? S_WR : S_RD_W;
      end
      S_RD_W: if (!master_waitrequest) state_d = S_WT_W;
      S_WT_W: if (master_readdatavalid) begin
        w_d     = master_readdata;
        state_d = S_RD_A;
      end
      S_RD_A: if (!master_waitrequest) state_d = S_WT_A;
      S_WT_A: if (master_readdatavalid) begin
        a_d     = master_readdata;
        state_d = S_MAC;
      end
      S_MAC: begin
        index_d = index_q + 32'd1;
        state_d = (index_q + 32'd1 == len_q) ? S_WR : S_RD_W;
      end
      S_WR: if (!master_waitrequest) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      w_q      <= '0;
      a_q      <= '0;
      wbase_q  <= '0;
      abase_q  <= '0;
      bias_q   <= '0;
      oaddr_q  <= '0;
      len_q    <= '0;
      result_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      w_q      <= w_d;
      a_q      <= a_d;
      wbase_q  <= wbase_d;
      abase_q  <= abase_d;
      bias_q   <= bias_d;
      oaddr_q  <= oaddr_d;
      len_q    <= len_d;
      result_q <= result_d;
      rdata_q  <= rdata_d;
    end
  end
  // Master strobes and address decode straight from registered state, so they hold during waitrequest
  assign master_read       = state_q == S_RD_W || state_q == S_RD_A;
  assign master_write      = state_q == S_WR;
  assign master_address    = ADDR_W'(state_q == S_RD_W ? wbase_q + (index_q << 2) :
                                     state_q == S_RD_A ? abase_q + (index_q << 2) :
                                     state_q == S_WR   ? oaddr_q : 32'd0);
  assign master_writedata  = master_write ? final_val : '0;
  assign slave_readdata    = rdata_q;
  assign slave_waitrequest = busy;
endmodule

// File: tb/tb_dot_accel.sv
// tb_dot_accel: scoreboard bench for dot_accel with an Avalon SDRAM model and arithmetic reference
module tb_dot_accel;
  logic        clk = 0, reset = 1;
  logic [2:0]  slave_address = '0;
  logic        slave_read = 0, slave_write = 0;
  logic [31:0] slave_writedata = '0, slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] master_address, master_writedata;
  logic        master_read, master_write;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 0, master_waitrequest = 0;

  dot_accel dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_waitrequest(slave_waitrequest),
    .master_address(master_address), .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  int          n_chk = 0, n_fail = 0, rd_cnt = 0, wr_cnt = 0, cnt = 0;
  bit          stall_en = 0, pend = 0, prev_hold = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wv [8], av [8];
  logic [31:0] paddr, prev_addr, prev_wd;
  logic        prev_read, prev_write;
  wr_t         exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM model and write monitor: everything sampled and driven on the falling edge
  always @(negedge clk) begin
    wr_t e;
    master_readdatavalid = 0;
    if (reset) pend = 0;
    else if (pend) begin
      if (cnt == 0) begin
        master_readdatavalid = 1;
        master_readdata = mem.exists(paddr) ? mem[paddr] : $urandom;
        pend = 0;
      end else cnt--;
    end
    if (!reset && prev_hold) begin
      chk("stable_ctl", {30'b0, master_read, master_write}, {30'b0, prev_read, prev_write});
      chk("stable_addr", master_address, prev_addr);
      chk("stable_wdata", master_writedata, prev_wd);
    end
    master_waitrequest = stall_en ? ($urandom_range(0, 2) != 0) : 1'b0;
    if (!reset && master_read && !master_waitrequest) begin
      pend = 1;
      paddr = master_address;
      cnt = stall_en ? $urandom_range(0, 7) : 0;
      rd_cnt++;
    end
    if (!reset && master_write && !master_waitrequest) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got %h at %h expected none", master_writedata, master_address);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", master_address, e.addr);
        chk("wr_data", master_writedata, e.data);
      end
    end
    prev_hold  = master_waitrequest && (master_read || master_write);
    prev_read  = master_read;
    prev_write = master_write;
    prev_addr  = master_address;
    prev_wd    = master_writedata;
  end

  function automatic logic [31:0] model(input int n, input logic [31:0] b, input bit relu);
    int acc = int'(b);
    for (int i = 0; i < n; i++) begin
      longint p = longint'($signed(wv[i])) * longint'($signed(av[i]));
      acc += int'(p >>> 16);
    end
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    int waits = 0;
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1;
    while (slave_waitrequest && waits < 5000) begin waits++; @(negedge clk); end
    if (waits >= 5000) begin n_chk++; n_fail++; $display("FAIL cpu_write_timeout: got stalled expected accept"); end
    @(negedge clk);
    slave_write = 0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    slave_address = a; slave_read = 1;
    while (slave_waitrequest && waits < 5000) begin waits++; @(negedge clk); end
    if (waits >= 5000) begin n_chk++; n_fail++; $display("FAIL cpu_read_timeout: got stalled expected accept"); end
    @(negedge clk);
    slave_read = 0;
    d = slave_readdata;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (slave_waitrequest && cyc < 5000) begin cyc++; @(negedge clk); end
  endtask

  task automatic program_regs(input int n, input logic [31:0] b, input bit relu, input logic [31:0] ob);
    for (int i = 0; i < n; i++) begin
      mem[32'h1000 + 32'(4 * i)] = wv[i];
      mem[32'h2000 + 32'(4 * i)] = av[i];
    end
    cpu_write(1, 32'h1000);
    cpu_write(2, 32'h2000);
    cpu_write(3, b);
    cpu_write(4, ob);
    cpu_write(5, n);
    cpu_write(6, {31'b0, relu});
  endtask

  task automatic run(input int n, input logic [31:0] b, input bit relu, input int exp_cyc, input bit mid_read);
    logic [31:0] e, r, ob;
    int cyc, waits, rd0;
    ob = 32'h3000 + 32'($urandom_range(0, 255) * 4);
    e = model(n, b, relu);
    program_regs(n, b, relu, ob);
    exp_q.push_back('{ob, e});
    rd0 = rd_cnt;
    cpu_write(0, 1);
    if (mid_read) begin
      cpu_read(0, r, waits);
      chk("status_stalled_val", r, 0);
      chk("status_stalled_seen", 32'(waits > 0), 1);
    end else begin
      wait_idle(cyc);
      if (exp_cyc >= 0) chk("cycles", cyc, exp_cyc);
    end
    chk("reads", rd_cnt - rd0, 2 * n);
    chk("pending_writes", exp_q.size(), 0);
    cpu_read(7, r, waits);
    chk("result", r, e);
    cpu_read(0, r, waits);
    chk("status_idle", r, 0);
  endtask

  initial begin
    logic [31:0] r;
    int waits, k, w0, rd0;
    repeat (2) @(negedge clk);
    chk("rst_master", {master_read, master_write, 30'b0}, 0);
    chk("rst_addr", master_address, 0);
    chk("rst_wdata", master_writedata, 0);
    chk("rst_slave", {slave_waitrequest, 31'b0}, 0);
    chk("rst_rdata", slave_readdata, 0);
    reset = 0;
    cpu_read(0, r, waits);
    chk("rst_status", r, 0);
    cpu_read(7, r, waits);
    chk("rst_result", r, 0);
    cpu_write(6, 1);
    cpu_read(6, r, waits);
`ifdef DOT_ACCEL_RELU_EN
    chk("relu_reg", r, 1);
`else
    chk("relu_reg", r, 0);
`endif
    // basic vector
    wv[0] = 32'h00010000; wv[1] = 32'h00020000; wv[2] = 32'hFFFF8000;
    av[0] = 32'h00030000; av[1] = 32'h00008000; av[2] = 32'h00040000;
    chk("model_basic", model(3, 32'h8000, 0), 32'h00028000);
    run(3, 32'h00008000, 0, 16, 0);
    run(0, 32'h12345678, 0, 1, 0);
`ifdef DOT_ACCEL_RELU_EN
    wv[0] = 32'h00010000; av[0] = 32'hFFFE0000;
    run(1, 0, 1, 6, 0);
    run(1, 0, 0, 6, 0);
`endif
    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin wv[i] = $urandom; av[i] = $urandom; end
      run(n, $urandom, 0, 5 * n + 1, 0);
    end
    stall_en = 1;
    wv[0] = 32'h00010000; wv[1] = 32'h00020000; wv[2] = 32'hFFFF8000;
    av[0] = 32'h00030000; av[1] = 32'h00008000; av[2] = 32'h00040000;
    run(3, 32'h00008000, 0, -1, 1);
    run(3, 32'h00008000, 0, -1, 0);
    for (int t = 0; t < 2; t++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin wv[i] = $urandom; av[i] = $urandom; end
      run(n, $urandom, 0, -1, 1);
    end
    stall_en = 0;
    repeat (3) @(negedge clk);
    // reset while waiting on the second activation
    wv[0] = 32'h00010000; wv[1] = 32'h00020000; wv[2] = 32'hFFFF8000;
    av[0] = 32'h00030000; av[1] = 32'h00008000; av[2] = 32'h00040000;
    program_regs(3, 32'h8000, 0, 32'h3000);
    rd0 = rd_cnt;
    w0 = wr_cnt;
    cpu_write(0, 1);
    k = 0;
    while (rd_cnt < rd0 + 4 && k < 500) begin @(posedge clk); k++; end
    chk("reset_reached_wt_a", rd_cnt - rd0, 4);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_strobes", {master_read, master_write, 30'b0}, 0);
    chk("midrst_idle", {slave_waitrequest, 31'b0}, 0);
    reset = 0;
    repeat (12) @(negedge clk);
    chk("midrst_no_write", wr_cnt - w0, 0);
    cpu_read(7, r, waits);
    chk("midrst_result", r, 0);
    run(3, 32'h00008000, 0, 16, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
